// File: rtl/soc_ram_arbiter.sv
// soc_ram_arbiter: round-robin arbiter for two masters sharing a single-port synchronous RAM.
// Optional bounded lock lets one master hold the RAM for up to MAX_BURST consecutive grants.
module soc_ram_arbiter #(
    parameter int DW        = 16,
    parameter int RAM_AW    = 7,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [RAM_AW-1:0] m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DW-1:0]     m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [RAM_AW-1:0] m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DW-1:0]     m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;
    logic [1:0]    state;
    logic          last;
    logic [CW-1:0] cnt;
    logic          lock_sel;
    // last is the index of the most recent winner; a tie goes to the other master
    always_comb begin
        m0_gnt    = !rst && m0_req && (state == LOCK0 || (state == ARB && (!m1_req || last)));
        m1_gnt    = !rst && m1_req && (state == LOCK1 || (state == ARB && (!m0_req || !last)));
        ram_en    = m0_gnt || m1_gnt;
        ram_we    = m0_gnt ? m0_we    : m1_gnt ? m1_we    : 1'b0;
        ram_addr  = m0_gnt ? m0_addr  : m1_gnt ? m1_addr  : '0;
        ram_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
        lock_sel  = m0_gnt ? m0_lock  : m1_gnt && m1_lock;
        m0_rdata  = m0_rvalid ? ram_rdata : '0;
        m1_rdata  = m1_rvalid ? ram_rdata : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            last      <= 1'b1;
            cnt       <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (ram_en)
                last <= m1_gnt;
            // a single-grant burst limit never needs the lock states
            if (state == ARB) begin
                if (lock_sel && MAX_BURST > 1) begin
                    state <= m0_gnt ? LOCK0 : LOCK1;
                    cnt   <= CW'(1);
                end
            end else if (!ram_en || !lock_sel || cnt == CW'(MAX_BURST - 1)) begin
                state <= ARB;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_soc_ram_arbiter.sv
// tb_soc_ram_arbiter: directed tests with a per-cycle owner/turn model and a simple RAM.
module tb_soc_ram_arbiter;
    localparam int DW = 16, AW = 7, MB = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req = '0, we = '0, lock = '0;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic [1:0] gnt, rvalid;
    logic [DW-1:0] rdata [2];
    logic ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [DW-1:0] ram [128];
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    soc_ram_arbiter #(.DW(DW), .RAM_AW(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]),
        .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else ram_rdata <= ram[ram_addr];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: an owner (or none) holding the RAM, grants taken in its burst, last winner.
    logic [DW-1:0] mem [128];
    int owner = -1, burst = 0, last = 1;
    logic [1:0] exp_rv = '0;
    logic [DW-1:0] exp_rd [2];
    always @(negedge clk) begin
        int g;
        logic [1:0] nrv;
        logic [DW-1:0] nrd [2];
        if (rst) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_ram_en", 32'(ram_en), 0);
            chk("rst_rvalid", 32'(rvalid), 0);
            chk("rst_rdata0", 32'(rdata[0]), 0);
            chk("rst_rdata1", 32'(rdata[1]), 0);
            owner = -1; burst = 0; last = 1; exp_rv = '0;
        end else begin
            g = -1;
            if (owner >= 0) g = req[owner] ? owner : -1;
            else if (req == 2'b11) g = 1 - last;
            else if (req[0]) g = 0;
            else if (req[1]) g = 1;
            chk("gnt0", 32'(gnt[0]), 32'(g == 0));
            chk("gnt1", 32'(gnt[1]), 32'(g == 1));
            chk("ram_en", 32'(ram_en), 32'(g >= 0));
            chk("ram_we", 32'(ram_we), g >= 0 ? 32'(we[g]) : 0);
            chk("ram_addr", 32'(ram_addr), g >= 0 ? 32'(addr[g]) : 0);
            chk("ram_wdata", 32'(ram_wdata), g >= 0 ? 32'(wdata[g]) : 0);
            for (int i = 0; i < 2; i++) begin
                chk("rvalid", 32'(rvalid[i]), 32'(exp_rv[i]));
                chk("rdata", 32'(rdata[i]), exp_rv[i] ? 32'(exp_rd[i]) : 0);
            end
            nrv = '0;
            nrd[0] = '0; nrd[1] = '0;
            if (g >= 0) begin
                if (we[g]) mem[addr[g]] = wdata[g];
                else begin nrv[g] = 1'b1; nrd[g] = mem[addr[g]]; end
                last = g;
                if (owner < 0) begin
                    if (lock[g]) begin owner = g; burst = 1; end
                end else begin
                    burst++;
                    if (!lock[g]) owner = -1;
                end
                if (owner >= 0 && burst >= MB) owner = -1;
            end else owner = -1;
            exp_rv = nrv;
            exp_rd = nrd;
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i] = 16'(i * 257 + 3);
            mem[i] = 16'(i * 257 + 3);
        end
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (2) adv();
        rst = 1'b0;
        // 1: m0 write then read back
        req = 2'b01; we = 2'b01; addr[0] = 7'h05; wdata[0] = 16'hFA1C;
        @(negedge clk); chk("t1_wr_gnt", 32'(gnt[0]), 1);
        adv(); we = 2'b00;
        @(negedge clk); chk("t1_rd_gnt", 32'(gnt[0]), 1);
        adv(); req = 2'b00;
        @(negedge clk);
        chk("t1_rvalid", 32'(rvalid[0]), 1);
        chk("t1_rdata", 32'(rdata[0]), 32'hFA1C);
        chk("t1_m1_rvalid", 32'(rvalid[1]), 0);
        // 2: after reset, both reading continuously alternate starting with m0
        adv(); rst = 1'b1;
        adv(); rst = 1'b0;
        addr[0] = 7'h01; addr[1] = 7'h02;
        for (int k = 0; k < 7; k++) begin
            req = k < 6 ? 2'b11 : 2'b00;
            @(negedge clk);
            if (k < 6) chk("t2_order", 32'(gnt), k % 2 == 0 ? 32'h1 : 32'h2);
            if (k > 0) chk("t2_rvalid", 32'(rvalid), (k - 1) % 2 == 0 ? 32'h1 : 32'h2);
            adv();
        end
        // make m0 the last winner so m1 takes the tie into its burst
        req = 2'b01; addr[0] = 7'h05;
        @(negedge clk); adv();
        // 3: m1 locked burst capped at MB grants
        req = 2'b11; lock = 2'b10; addr[1] = 7'h10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_gnt", 32'(gnt), k < 4 ? 32'h2 : 32'h1);
            adv();
        end
        req = 2'b00; lock = 2'b00;
        @(negedge clk); adv();
        // 4: m0 burst released by dropping lock on its 2nd grant
        req = 2'b01; lock = 2'b01; addr[0] = 7'h20;
        @(negedge clk); chk("t4_g1", 32'(gnt), 1);
        adv(); req = 2'b11; lock = 2'b00;
        @(negedge clk); chk("t4_g2", 32'(gnt), 1);
        adv();
        @(negedge clk); chk("t4_m1", 32'(gnt), 2);
        adv(); req = 2'b01;
        @(negedge clk); chk("t4_m0", 32'(gnt), 1);
        adv(); req = 2'b00;
        @(negedge clk); adv();
        // 5: async reset right after an m1 read grant
        req = 2'b10; addr[1] = 7'h33;
        @(negedge clk); chk("t5_gnt", 32'(gnt), 2);
        @(posedge clk); #2; rst = 1'b1; req = 2'b11;
        @(negedge clk);
        chk("t5_rvalid", 32'(rvalid[1]), 0);
        chk("t5_rst_gnt", 32'(gnt), 0);
        adv(); rst = 1'b0;
        @(negedge clk); chk("t5_tie", 32'(gnt), 1);
        adv(); req = 2'b10;
        @(negedge clk); adv(); req = 2'b00;
        @(negedge clk); adv();
        // 6: m0 write and m1 read of the same address in one cycle
        req = 2'b11; we = 2'b01; addr[0] = 7'h7F; wdata[0] = 16'h1234; addr[1] = 7'h7F;
        @(negedge clk); chk("t6_first", 32'(gnt), 1);
        adv(); req = 2'b10; we = 2'b00;
        @(negedge clk); chk("t6_second", 32'(gnt), 2);
        adv(); req = 2'b00;
        @(negedge clk);
        chk("t6_rvalid", 32'(rvalid[1]), 1);
        chk("t6_rdata", 32'(rdata[1]), 32'h1234);
        repeat (3) adv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
